// File: rtl/mem_wb_stage_pkg.sv
// Shared opcode constants, FSM state encoding and opcode-class helpers for the
// memory/write-back stage.
package mem_wb_stage_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_LSH  = 5'd6;
    localparam logic [4:0] OP_RSH  = 5'd7;
    localparam logic [4:0] OP_ARSH = 5'd8;
    localparam logic [4:0] OP_CMP  = 5'd9;
    localparam logic [4:0] OP_BRQ  = 5'd10;
    localparam logic [4:0] OP_BRG  = 5'd11;
    localparam logic [4:0] OP_BRS  = 5'd12;
    localparam logic [4:0] OP_LDW  = 5'd13;
    localparam logic [4:0] OP_STR  = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // ALU range plus CMP: results that go straight to the register file.
    function automatic logic is_alu_op(input logic [4:0] op);
        return ((op >= OP_ADD) && (op <= OP_ARSH)) || (op == OP_CMP);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LDW) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_wb_stage_watchdog.sv
// Cycle counter for the MEM state; expired_o flags the cycle in which the
// count reaches TIMEOUT while counting is enabled.
module mem_wb_watchdog
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds completed MEM cycles, so this cycle is number count_q+1.
    assign expired_o = en_i && ((count_q + 8'd1) == 8'(TIMEOUT));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage: ALU results retire in one cycle, LDW/STR
// run a request/ack memory access. Optional watchdog under MEM_WB_TIMEOUT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DADDR_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid_i,
    input  logic [4:0]         ex_opcode_i,
    input  logic [31:0]        ex_result_i,
    input  logic [31:0]        ex_store_data_i,
    input  logic [3:0]         ex_dest_i,
    output logic               stall_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [DADDR_W-1:0] dmem_addr_o,
    output logic [31:0]        dmem_wdata_o,
    input  logic [31:0]        dmem_rdata_i,
    input  logic               dmem_ack_i,
    output logic               rf_we_o,
    output logic [3:0]         rf_waddr_o,
    output logic [31:0]        rf_wdata_o,
    output logic               mem_error_o,
    output logic [1:0]         dbg_state_o
);

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT must be within 1..255");
    end

    state_t             state_q, state_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [DADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    logic               is_store_q, is_store_d;
    logic [3:0]         dest_q, dest_d;
    logic               rf_we_q, rf_we_d;
    logic [3:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               wd_expired;

    always_comb begin
        state_d      = state_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        is_store_d   = is_store_q;
        dest_d       = dest_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i && is_alu_op(ex_opcode_i)) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ex_dest_i;
                    rf_wdata_d = ex_result_i;
                end else if (ex_valid_i && is_mem_op(ex_opcode_i)) begin
                    dmem_addr_d  = ex_result_i[DADDR_W-1:0];
                    dmem_wdata_d = ex_store_data_i;
                    is_store_d   = (ex_opcode_i == OP_STR);
                    dest_d       = ex_dest_i;
                    state_d      = ST_MEM;
                end
            end
            ST_MEM: begin
                // An ack always beats a simultaneous watchdog expiry.
                if (dmem_ack_i) begin
                    if (is_store_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_WB;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = dest_q;
                        rf_wdata_d = dmem_rdata_i;
                    end
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && is_store_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'd0;
            is_store_q   <= 1'b0;
            dest_q       <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 4'd0;
            rf_wdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            is_store_q   <= is_store_d;
            dest_q       <= dest_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    logic mem_error_q;

    mem_wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != ST_MEM),
        .en_i     (state_q == ST_MEM),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error_q <= 1'b0;
        end else begin
            mem_error_q <= wd_expired && !dmem_ack_i;
        end
    end

    assign mem_error_o = mem_error_q;
`else
    assign wd_expired  = 1'b0;
    assign mem_error_o = 1'b0;
`endif

    assign stall_o      = (state_q != ST_IDLE);
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DADDR_W, default 8: data-memory address width; address = ex_result[DADDR_W-1:0].
REQ-002 Parameter TIMEOUT, default 15: maximum cycles spent in MEM without dmem_ack (range 1..255).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ex_valid  in  1  execute-stage result valid this cycle.
REQ-006 ex_opcode  in  5  opcode of the result, using the shared opcode constants.
REQ-007 ex_result  in  32  signed ALU / CMP result, or load/store address.
REQ-008 ex_store_data  in  32  store operand for STR.
REQ-009 ex_dest  in  4  destination register index.
REQ-010 stall  out  1  hold request to upstream; ex_* must be held stable while high.
REQ-011 dmem_req, dmem_we  out  1 each  data-memory request and write enable.
REQ-012 dmem_addr  out  DADDR_W  memory address; dmem_wdata  out  32  store data.
REQ-013 dmem_rdata  in  32  load data; dmem_ack  in  1  request completed this cycle.
REQ-014 rf_we  out  1  register-file write strobe; rf_waddr  out  4  index; rf_wdata  out  32  data.
REQ-015 mem_error  out  1  one-cycle pulse on memory timeout.

Function
REQ-016 FSM states: IDLE, MEM, WB; stall SHALL be high exactly when state is MEM or WB.
REQ-017 In IDLE with ex_valid high: opcodes ADD..ARSH and CMP SHALL produce rf_we=1, rf_waddr=ex_dest, rf_wdata=ex_result on the next cycle (latency 1); FSM stays in IDLE.
REQ-018 NOP, BRQ, BRG and BRS SHALL be consumed without any register or memory access.
REQ-019 LDW/STR in IDLE SHALL latch address, store data, dest and write direction, then enter MEM the next cycle.
REQ-020 In MEM: dmem_req=1 and dmem_we=(STR); dmem_addr and dmem_wdata SHALL remain stable until the ack cycle.
REQ-021 On dmem_ack in MEM: STR returns to IDLE; LDW captures dmem_rdata and enters WB.
REQ-022 WB SHALL assert rf_we for exactly one cycle with the latched dest and load data, then return to IDLE.
REQ-023 Load timing: accepted at edge T, ack seen at edge T+k, rf_we high during cycle T+k+1, next instruction accepted at T+k+2.
REQ-024 When not in MEM, dmem_ack is ignored; when ex_valid is low in IDLE, all strobes are 0.
REQ-025 Outputs are registered; rf_we is never asserted in the same cycle as dmem_req.

Reset
REQ-026 On rst: state=IDLE, stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, mem_error=0, watchdog count=0.
REQ-027 Reset during MEM or WB SHALL abort the operation with no register write; dmem_req SHALL be low in the cycle after rst is sampled.

Configuration
REQ-028 Macro MEM_WB_TIMEOUT_EN defined: the watchdog counts cycles in MEM; at count==TIMEOUT with no ack, it drops dmem_req, pulses mem_error, performs no write and returns to IDLE.
REQ-029 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win: normal completion, no error.
REQ-030 Macro MEM_WB_TIMEOUT_EN undefined: MEM waits indefinitely, mem_error is tied 0 and no counter logic is present.

Structure
REQ-031 Opcode constants and the FSM state encoding SHALL live in the shared opcodes package/header.
REQ-032 The watchdog SHALL be a sub-module, mem_wb_watchdog (clear, count enable, expired), instantiated only under MEM_WB_TIMEOUT_EN.

Verification
REQ-033 ADD accepted with ex_result=0x0000_0007 and ex_dest=3 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=7; stall stays 0.
REQ-034 LDW with ex_result=0x12, ack on the 3rd MEM cycle, dmem_rdata=0xDEAD_BEEF, ex_dest=5 -> dmem_addr=0x12, stall high for 4 cycles, one rf_we with 0xDEADBEEF to register 5.
REQ-035 STR with ex_result=0x40 and ex_store_data=0xA5A5_A5A5, ack after 1 cycle -> dmem_we=1 and wdata=0xA5A5A5A5 for 1 cycle; no rf_we; back in IDLE.
REQ-036 With MEM_WB_TIMEOUT_EN set, LDW and no ack -> after 15 MEM cycles, mem_error pulses once, no rf_we; a case with ack on cycle 15 completes normally.
REQ-037 rst asserted on the 2nd MEM cycle of an LDW -> dmem_req=0 the next cycle, no rf_we, all outputs at reset values.
REQ-038 BRQ followed by NOP, then CMP with result 2 to register 1 -> only one rf_we (reg 1, value 2) and no memory traffic.
